// File: rtl/seg_pkg.sv
// Shared segment-code constants and slot type for the seven-segment scan driver.
package seg_pkg;

    typedef logic [1:0] slot_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry 0 is the rightmost element: SEG_TBL[0] = '0', SEG_TBL[9] = '9'.
    localparam logic [9:0][6:0] SEG_TBL = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Digit/segment bundle between a display client and the scan driver.
interface seg_scan_driver_if;

    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an;
    logic        frame;

    modport master (
        output enable, digits, dp,
        input  seg, seg_dp, an, frame
    );

    modport slave (
        input  enable, digits, dp,
        output seg, seg_dp, an, frame
    );

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment lookup; non-decimal codes go blank.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd < 4'd10) begin
            seg = SEG_TBL[bcd];
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with per-scan input snapshot.
// Optional leading-zero blanking: define SEG_SCAN_LZ_BLANK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic              clk,
    input  logic              reset,
    seg_scan_driver_if.slave  bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0] psc;
    slot_t         slot;
    logic [15:0]   sh_dig;
    logic [3:0]    sh_dp;

    logic          wrap;
    logic          load;
    logic          blank;
    logic [3:0]    cur;
    logic [6:0]    raw;
    logic [6:0]    nxt_seg;

    assign wrap = (psc == PMAX);
    assign load = (psc == '0) && (slot == 2'd0);
    assign cur  = sh_dig[{slot, 2'b00} +: 4];

    bcd_to_seg u_dec (
        .bcd (cur),
        .seg (raw)
    );

`ifdef SEG_SCAN_LZ_BLANK_EN
    // A digit blanks only when it and every digit to its left are zero.
    always_comb begin
        blank = 1'b0;
        unique case (slot)
            2'd3:    blank = (sh_dig[15:12] == 4'd0);
            2'd2:    blank = (sh_dig[15:8]  == 8'd0);
            2'd1:    blank = (sh_dig[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign nxt_seg = blank ? SEG_BLANK : raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            psc        <= '0;
            slot       <= 2'd0;
            sh_dig     <= '0;
            sh_dp      <= '0;
            bus.an     <= '0;
            bus.seg    <= SEG_BLANK;
            bus.seg_dp <= 1'b0;
            bus.frame  <= 1'b0;
        end else if (bus.enable) begin
            psc <= wrap ? '0 : psc + 1'b1;
            if (wrap) begin
                slot <= slot + 2'd1;
            end
            if (load) begin
                sh_dig <= bus.digits;
                sh_dp  <= bus.dp;
            end
            // Outputs follow the pre-edge slot and shadow.
            bus.an     <= 4'b0001 << slot;
            bus.seg    <= nxt_seg;
            bus.seg_dp <= sh_dp[slot];
            bus.frame  <= wrap && (slot == 2'd3);
        end else begin
            bus.frame <= 1'b0;
        end
    end

endmodule
